// File: rtl/lenet_window_sampler.sv
// Box-filters the centred display window of the pixel stream into a LeNet
// input image and streams it to the CNN over valid/ready.
module lenet_window_sampler #(
    parameter int widthlength  = 8,
    parameter int heightlength = 8,
    parameter int lenet_size   = 28,
    parameter int hRez         = 640,
    parameter int vRez         = 480
) (
    input  logic       clk25,
    input  logic       rst_n,
    input  logic       en,
    input  logic       frame_start,
    input  logic       pix_valid,
    input  logic [3:0] pix_data,
    output logic [7:0] cnn_data,
    output logic       cnn_valid,
    input  logic       cnn_ready,
    output logic       cnn_last,
    input  logic       cnn_done,
    output logic       busy
);

    localparam int WIN_W = widthlength * lenet_size;
    localparam int WIN_H = heightlength * lenet_size;
    localparam int X0    = hRez / 2 - widthlength * lenet_size / 2;
    localparam int Y0    = vRez / 2 - heightlength * lenet_size / 2;
    localparam int N     = lenet_size * lenet_size;
    localparam int XW    = $clog2(hRez);
    localparam int YW    = $clog2(vRez);
    localparam int IW    = $clog2(N);
    localparam int BW    = $clog2(lenet_size);
    localparam int AW    = $clog2(widthlength * heightlength * 15 + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_STREAM,
        S_WAIT
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          frame_over;

    logic [AW-1:0] acc [lenet_size];
    logic [7:0]    mem [N];

    logic          pix_ok;
    logic          in_win;
    logic [XW-1:0] wx;
    logic [YW-1:0] wy;
    logic [BW-1:0] bx;
    logic [BW-1:0] by;
    logic          sub_x_last;
    logic          sub_y_last;
    logic [IW-1:0] wr_idx;
    logic [AW-1:0] acc_sum;
    logic [7:0]    sample;
    logic          cap_pix;
    logic          blk_end;
    logic          last_wr;
    logic          acc_clr;
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] rd_nxt;

    // A pixel coinciding with frame_start belongs to no frame.
    assign pix_ok = pix_valid && !frame_start && !frame_over;

    assign in_win = (int'(x) >= X0) && (int'(x) < X0 + WIN_W) &&
                    (int'(y) >= Y0) && (int'(y) < Y0 + WIN_H);

    assign wx = x - XW'(X0);
    assign wy = y - YW'(Y0);
    assign bx = BW'(wx / XW'(widthlength));
    assign by = BW'(wy / YW'(heightlength));
    assign sub_x_last = (wx % XW'(widthlength)) == XW'(widthlength - 1);
    assign sub_y_last = (wy % YW'(heightlength)) == YW'(heightlength - 1);
    assign wr_idx = IW'(by) * IW'(lenet_size) + IW'(bx);

    assign acc_sum = acc[bx] + AW'(pix_data);
    assign sample  = 8'(acc_sum >> (AW - 8));

    assign cap_pix = (state_q == S_CAPTURE) && pix_ok && in_win;
    assign blk_end = cap_pix && sub_x_last && sub_y_last;
    assign last_wr = blk_end && (wr_idx == IW'(N - 1));
    assign acc_clr = frame_start &&
                     ((state_q == S_IDLE) || (state_q == S_CAPTURE));

    assign rd_nxt = rd_idx + IW'(1);
    assign busy   = (state_q != S_IDLE);

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            x          <= '0;
            y          <= '0;
            frame_over <= 1'b0;
        end else if (frame_start) begin
            x          <= '0;
            y          <= '0;
            frame_over <= 1'b0;
        end else if (pix_valid && !frame_over) begin
            if (x == XW'(hRez - 1)) begin
                x <= '0;
                if (y == YW'(vRez - 1)) begin
                    y          <= '0;
                    frame_over <= 1'b1;
                end else begin
                    y <= y + YW'(1);
                end
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (frame_start && en) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (frame_start) state_d = en ? S_CAPTURE : S_IDLE;
                else if (last_wr) state_d = S_STREAM;
            end
            S_STREAM: begin
                if (cnn_valid && cnn_ready && cnn_last) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnn_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // One accumulator per block column; it is reused for every block row.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < lenet_size; i++) acc[i] <= '0;
        end else if (acc_clr) begin
            for (int i = 0; i < lenet_size; i++) acc[i] <= '0;
        end else if (cap_pix) begin
            acc[bx] <= blk_end ? '0 : acc_sum;
        end
    end

    always_ff @(posedge clk25) begin
        if (blk_end) mem[wr_idx] <= sample;
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            cnn_valid <= 1'b0;
            cnn_last  <= 1'b0;
            cnn_data  <= '0;
            rd_idx    <= '0;
        end else if (state_q == S_STREAM) begin
            if (!cnn_valid) begin
                cnn_valid <= 1'b1;
                cnn_last  <= (N == 1);
                cnn_data  <= mem[0];
                rd_idx    <= '0;
            end else if (cnn_ready) begin
                if (cnn_last) begin
                    cnn_valid <= 1'b0;
                    cnn_last  <= 1'b0;
                end else begin
                    rd_idx   <= rd_nxt;
                    cnn_data <= mem[rd_nxt];
                    cnn_last <= (rd_nxt == IW'(N - 1));
                end
            end
        end
    end

endmodule
